dropout_stream: RTL

Parametrised, synthesizable dropout stage for the neuron datapath. Accepts a beat of `LANES` activations over a valid/ready handshake and zeroes each lane independently when a per-lane LFSR sample falls below a programmable rate. Emits the masked beat plus its keep mask. Replaces simulator-only `$urandom` randomness with deterministic, seedable hardware generators, and adds an inference pass-through mode, a drop counter and optional inverted-dropout scaling.

---
 rtl/dropout_pkg.sv | 21 ++
 rtl/dropout_stream_if.sv | 24 ++
 rtl/dropout_lfsr.sv | 27 ++
 rtl/dropout_stream.sv | 113 +++++++++++
 4 files changed

// File: rtl/dropout_pkg.sv
// Shared constants and seed helpers for the dropout lane generators.
// Pure declarations; no state, no handshake.
package dropout_pkg;

    localparam int LFSR_W = 32;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] LANE_SALT = 32'h9E37_79B9;

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    function automatic logic [LFSR_W-1:0] seed_for_lane(input logic [LFSR_W-1:0] base,
                                                        input int lane);
        logic [LFSR_W-1:0] s;
        s = base ^ (LANE_SALT * LFSR_W'(lane + 1));
        return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/dropout_stream_if.sv
// Beat stream into and out of the dropout stage: valid/ready on both sides.
// The slave modport is the dropout stage, the master modport is its environment.
interface dropout_stream_if #(
    parameter int LANES  = 8,
    parameter int DATA_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LANES-1:0]        out_mask;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_mask
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_mask
    );
endinterface

// File: rtl/dropout_lfsr.sv
// One 32-bit right-shifting Galois LFSR per lane; load beats step.
// Latency: new state visible the cycle after load/step. No handshake of its own.
// Backpressure: none; the parent only asserts step on an accepted training beat.
module dropout_lfsr
    import dropout_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = 32'h1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_VAL;
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/dropout_stream.sv
// Per-lane LFSR dropout of an activation beat; optional inverted scaling under DROPOUT_SCALE_EN.
// Latency: 1 cycle from acceptance to out_valid; full throughput.
// Backpressure: in_ready = ena && (!out_valid || out_ready); held output stays stable.
module dropout_stream
    import dropout_pkg::*;
#(
    parameter int          LANES  = 8,
    parameter int          DATA_W = 8,
    parameter int          RATE_W = 8,
    parameter logic [31:0] SEED   = 32'hACE1_2024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              train_mode,
    input  logic [RATE_W-1:0] cfg_rate,
    input  logic [31:0]       cfg_seed,
    input  logic              cfg_seed_load,
    input  logic [1:0]        cfg_shift,
    dropout_stream_if.slave   bus,
    output logic [15:0]       drop_cnt
);

    localparam int CNT_W = $clog2(LANES + 1);

    logic                    accept;
    logic                    step;
    logic [RATE_W-1:0]       sample [LANES];
    logic [LANES-1:0]        keep;
    logic [LANES*DATA_W-1:0] masked;
    logic [CNT_W-1:0]        drop_n;
    logic [16:0]             cnt_sum;

`ifdef DROPOUT_SCALE_EN
    function automatic logic [DATA_W-1:0] scale_lane(input logic [DATA_W-1:0] x,
                                                     input logic [1:0] sh);
        logic [DATA_W+2:0] wide;
        wide = {3'b000, x} << sh;
        return (wide[DATA_W+2:DATA_W] != 3'b000) ? '1 : wide[DATA_W-1:0];
    endfunction
`else
    function automatic logic [DATA_W-1:0] scale_lane(input logic [DATA_W-1:0] x,
                                                     input logic [1:0] sh);
        logic unused_sh;
        unused_sh = ^sh;
        return x;
    endfunction
`endif

    // Reset gates in_ready so nothing is accepted while the pipeline clears.
    assign bus.in_ready = !rst && ena && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign step         = accept && train_mode;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LFSR_W-1:0]        state;
        logic [LFSR_W-RATE_W-1:0] unused_hi;

        dropout_lfsr #(
            .RESET_VAL (seed_for_lane(SEED, i))
        ) u_lfsr (
            .clk   (clk),
            .rst   (rst),
            .load  (cfg_seed_load),
            .seed  (seed_for_lane(cfg_seed, i)),
            .step  (step),
            .state (state)
        );

        assign sample[i] = state[RATE_W-1:0];
        assign unused_hi = state[LFSR_W-1:RATE_W];
    end

    always_comb begin
        keep   = '1;
        masked = '0;
        drop_n = '0;
        for (int i = 0; i < LANES; i++) begin
            if (train_mode) begin
                keep[i] = (sample[i] >= cfg_rate);
                if (keep[i]) begin
                    masked[i*DATA_W +: DATA_W] = scale_lane(bus.in_data[i*DATA_W +: DATA_W], cfg_shift);
                end
            end else begin
                masked[i*DATA_W +: DATA_W] = bus.in_data[i*DATA_W +: DATA_W];
            end
            drop_n = drop_n + CNT_W'(!keep[i]);
        end
    end

    assign cnt_sum = {1'b0, drop_cnt} + 17'(drop_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_mask  <= '0;
            drop_cnt      <= '0;
        end else begin
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= masked;
                bus.out_mask  <= keep;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (step) begin
                drop_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            end
        end
    end

endmodule
